// File: rtl/ft245_bus_bridge_if.sv
// CPU-side and FIFO-side signal bundle for ft245_bus_bridge.
// master: the 68000 glue plus the FIFO pins; slave: the bridge itself.
interface ft245_bus_bridge_if;
    logic       sel_data;
    logic       sel_stat;
    logic       _as;
    logic       _ds;
    logic       rw;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_doe;
    logic       _dtack;
    logic [7:0] ft_din;
    logic [7:0] ft_dout;
    logic       ft_doe;
    logic       _rd;
    logic       wr;
    logic       _rdf;
    logic       _txe;
    logic       _irq;

    modport master (
        output sel_data, sel_stat, _as, _ds, rw, cpu_din, ft_din, _rdf, _txe,
        input  cpu_dout, cpu_doe, _dtack, ft_dout, ft_doe, _rd, wr, _irq
    );

    modport slave (
        input  sel_data, sel_stat, _as, _ds, rw, cpu_din, ft_din, _rdf, _txe,
        output cpu_dout, cpu_doe, _dtack, ft_dout, ft_doe, _rd, wr, _irq
    );
endinterface

// File: rtl/ft245_bus_bridge.sv
// Timing bridge between the 68000 decode glue and an FT245-style USB FIFO.
// Generates _rd / wr strobes of programmed width, latches receive data and
// holds off _dtack until the FIFO transfer has completed or timed out.
// Optional feature macro FT_IRQ_EN: adds the rx interrupt enable bit (rx_ie)
// written via the status address and drives _irq from it.
module ft245_bus_bridge #(
    parameter int unsigned RD_PULSE = 4,
    parameter int unsigned WR_SETUP = 1,
    parameter int unsigned WR_PULSE = 4,
    parameter int unsigned RECOV    = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic               clk,
    input logic               _reset,
    ft245_bus_bridge_if.slave bus
);

    localparam logic [7:0] RD_LAST  = 8'(RD_PULSE - 1);
    localparam logic [7:0] WS_LAST  = 8'(WR_SETUP - 1);
    localparam logic [7:0] WP_LAST  = 8'(WR_PULSE - 1);
    localparam logic [7:0] RC_LAST  = 8'(RECOV - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_STB, WR_WAIT, WR_SET, WR_STB, ACK, RECOVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;
    logic       abort_q, abort_d;
    logic       to_sticky_q, to_sticky_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic [7:0] ft_dout_q, ft_dout_d;
    logic       cpu_doe_q, cpu_doe_d;
    logic       dtack_n_q, dtack_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_q, wr_d;
    logic       ft_doe_q, ft_doe_d;
    logic       cyc_q, pend_q, pend_d;
    logic       rdf_meta_q, rdf_s_q, txe_meta_q, txe_s_q;
    logic       cyc, go, rx_ie_bit;

`ifdef FT_IRQ_EN
    logic rx_ie_q, rx_ie_d;
    logic irq_n_q, irq_n_d;
    assign rx_ie_bit = rx_ie_q;
`else
    assign rx_ie_bit = 1'b0;
`endif

    // A bus cycle is a qualified select with both strobes low. A rising edge
    // that lands while the FSM is still busy (e.g. RECOVER) is remembered in
    // pend_q so it is served once IDLE is reached, still only once per cycle.
    assign cyc = ~bus._as & ~bus._ds & (bus.sel_data | bus.sel_stat);
    assign go  = cyc & (~cyc_q | pend_q);

    // Next-state, datapath and output decode; outputs derive from state_d so
    // they register in step with the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        strobe_d    = strobe_q;
        abort_d     = abort_q;
        to_sticky_d = to_sticky_q;
        cpu_dout_d  = cpu_dout_q;
        ft_dout_d   = ft_dout_q;
        pend_d      = cyc & (pend_q | ~cyc_q) & (state_q != IDLE);
`ifdef FT_IRQ_EN
        rx_ie_d     = rx_ie_q;
`endif

        case (state_q)
            IDLE: begin
                strobe_d = 1'b0;
                abort_d  = 1'b0;
                cnt_d    = '0;
                if (go) begin
                    if (bus.sel_stat) begin
                        if (bus.rw) begin
                            cpu_dout_d  = {4'b0, rx_ie_bit, to_sticky_q, ~txe_s_q, ~rdf_s_q};
                            to_sticky_d = 1'b0;
                        end else begin
`ifdef FT_IRQ_EN
                            rx_ie_d = bus.cpu_din[0];
`endif
                        end
                        state_d = ACK;
                    end else if (bus.rw) begin
                        state_d = RD_WAIT;
                    end else begin
                        ft_dout_d = bus.cpu_din;
                        state_d   = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus._as) begin
                    state_d = IDLE;
                end else if (!rdf_s_q) begin
                    state_d = RD_STB;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cpu_dout_d  = 8'hFF;
                    to_sticky_d = 1'b1;
                    state_d     = ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_STB: begin
                strobe_d = 1'b1;
                abort_d  = abort_q | bus._as;
                if (cnt_q == RD_LAST) begin
                    cpu_dout_d = bus.ft_din;
                    cnt_d      = '0;
                    state_d    = (abort_q | bus._as) ? RECOVER : ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_WAIT: begin
                if (bus._as) begin
                    state_d = IDLE;
                end else if (!txe_s_q) begin
                    state_d = WR_SET;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    to_sticky_d = 1'b1;
                    state_d     = ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_SET: begin
                strobe_d = 1'b1;
                abort_d  = abort_q | bus._as;
                if (cnt_q == WS_LAST) begin
                    state_d = WR_STB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_STB: begin
                strobe_d = 1'b1;
                abort_d  = abort_q | bus._as;
                if (cnt_q == WP_LAST) begin
                    cnt_d   = '0;
                    state_d = (abort_q | bus._as) ? RECOVER : ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK: begin
                if (bus._as) begin
                    cnt_d   = '0;
                    state_d = strobe_q ? RECOVER : IDLE;
                end
            end
            RECOVER: begin
                if (cnt_q == RC_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        dtack_n_d = (state_d != ACK);
        cpu_doe_d = (state_d == ACK) & bus.rw;
        rd_n_d    = (state_d != RD_STB);
        wr_d      = (state_d == WR_STB);
        // ft_doe covers setup and pulse, plus the one cycle after wr falls.
        ft_doe_d  = (state_d == WR_SET) | (state_d == WR_STB) | (state_q == WR_STB);
`ifdef FT_IRQ_EN
        irq_n_d   = ~(rx_ie_q & ~rdf_s_q);
`endif
    end

    // Single state/output register; reset cuts any strobe immediately.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            abort_q     <= 1'b0;
            to_sticky_q <= 1'b0;
            cpu_dout_q  <= '0;
            ft_dout_q   <= '0;
            cpu_doe_q   <= 1'b0;
            dtack_n_q   <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_q        <= 1'b0;
            ft_doe_q    <= 1'b0;
            cyc_q       <= 1'b0;
            pend_q      <= 1'b0;
            rdf_meta_q  <= 1'b1;
            rdf_s_q     <= 1'b1;
            txe_meta_q  <= 1'b1;
            txe_s_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            abort_q     <= abort_d;
            to_sticky_q <= to_sticky_d;
            cpu_dout_q  <= cpu_dout_d;
            ft_dout_q   <= ft_dout_d;
            cpu_doe_q   <= cpu_doe_d;
            dtack_n_q   <= dtack_n_d;
            rd_n_q      <= rd_n_d;
            wr_q        <= wr_d;
            ft_doe_q    <= ft_doe_d;
            cyc_q       <= cyc;
            pend_q      <= pend_d;
            rdf_meta_q  <= bus._rdf;
            rdf_s_q     <= rdf_meta_q;
            txe_meta_q  <= bus._txe;
            txe_s_q     <= txe_meta_q;
        end
    end

`ifdef FT_IRQ_EN
    // Interrupt enable bit and registered active-low rx interrupt.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rx_ie_q <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            rx_ie_q <= rx_ie_d;
            irq_n_q <= irq_n_d;
        end
    end
    assign bus._irq = irq_n_q;
`else
    assign bus._irq = 1'b1;
`endif

    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cpu_doe  = cpu_doe_q;
    assign bus._dtack   = dtack_n_q;
    assign bus.ft_dout  = ft_dout_q;
    assign bus.ft_doe   = ft_doe_q;
    assign bus._rd      = rd_n_q;
    assign bus.wr       = wr_q;

endmodule
